instr_fetch_unit: RTL

Instruction fetch stage for the 8-bit AVR-style `cpu`. It sits between the instruction ROM (16-bit words, 10-bit word address) and the decode/execute state machine. It prefetches words into a small FIFO, tagging each with its PC. It presents complete one- or two-word instructions to the consumer with a valid/ready handshake, and flushes and redirects on jumps.

---
 rtl/instr_fetch_unit_if.sv | 37 +++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - ROM, redirect and instruction handshake bundle for instr_fetch_unit
`timescale 1ns/1ps
interface instr_fetch_unit_if #(
  parameter int INSTR_WIDTH  = 16,
  parameter int I_ADDR_WIDTH = 10
);
  logic [I_ADDR_WIDTH-1:0] rom_addr;
  logic                    rom_cs;
  logic                    rom_oe;
  logic [INSTR_WIDTH-1:0]  rom_data;
  logic                    jump_valid;
  logic [I_ADDR_WIDTH-1:0] jump_target;
  logic                    instr_valid;
  logic                    instr_ready;
  logic [INSTR_WIDTH-1:0]  instr;
  logic [INSTR_WIDTH-1:0]  instr_ext;
  logic                    instr_two_word;
  logic [I_ADDR_WIDTH-1:0] instr_pc;

  modport master (
    output rom_addr, rom_cs, rom_oe,
    input  rom_data,
    input  jump_valid, jump_target,
    output instr_valid,
    input  instr_ready,
    output instr, instr_ext, instr_two_word, instr_pc
  );

  modport slave (
    input  rom_addr, rom_cs, rom_oe,
    output rom_data,
    output jump_valid, jump_target,
    input  instr_valid,
    output instr_ready,
    input  instr, instr_ext, instr_two_word, instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - prefetching instruction fetch stage with PC-tagged FIFO and jump redirect
// Two-word (LDS/STS/JMP/CALL) assembly is enabled by defining FETCH_TWO_WORD_EN.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter int INSTR_WIDTH  = 16,
  parameter int I_ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam int EW = I_ADDR_WIDTH + INSTR_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  logic [1:0]              state;
  logic [1:0]              state_nx;
  logic [I_ADDR_WIDTH-1:0] fetch_pc;
  logic [I_ADDR_WIDTH-1:0] rom_addr_q;
  logic                    rom_cs_q;
  logic                    resp_valid;
  logic [I_ADDR_WIDTH-1:0] resp_addr;
  logic [CW-1:0]           count;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [EW-1:0]           mem [FIFO_DEPTH];

  logic                    jump;
  logic [EW-1:0]           head_entry;
  logic [INSTR_WIDTH-1:0]  head_word;
  logic [I_ADDR_WIDTH-1:0] head_addr;
  logic [INSTR_WIDTH-1:0]  ext_word;
  logic                    head_two;
  logic                    valid;
  logic                    handshake;
  logic [CW-1:0]           pop_n;
  logic                    push;
  logic [OW-1:0]           occupancy;
  logic                    space;

  assign jump       = bus.jump_valid;
  assign head_entry = mem[rd_ptr];
  assign head_word  = head_entry[INSTR_WIDTH-1:0];
  assign head_addr  = head_entry[EW-1:INSTR_WIDTH];

`ifdef FETCH_TWO_WORD_EN
  logic [PW-1:0] rd_ptr_nx;
  assign rd_ptr_nx = rd_ptr + PW'(1);
  assign ext_word  = mem[rd_ptr_nx][INSTR_WIDTH-1:0];
  assign head_two  = (head_word[15:10] == 6'b100100 && head_word[3:0] == 4'd0) ||
                     (head_word[15:9] == 7'b1001010 && head_word[3:2] == 2'b11);
`else
  assign ext_word  = '0;
  assign head_two  = 1'b0;
`endif

  // A two-word head is only presented once its second word has landed.
  assign valid     = (count != '0) && (!head_two || count > CW'(1));
  assign handshake = valid && bus.instr_ready;
  assign pop_n     = handshake ? (head_two ? CW'(2) : CW'(1)) : '0;
  assign push      = resp_valid && !jump;

  // Words already in the FIFO plus requests whose data has not been pushed yet.
  assign occupancy = OW'(count) + OW'(rom_cs_q) + OW'(resp_valid);
  assign space     = occupancy < OW'(FIFO_DEPTH);

  always_comb begin
    state_nx = state;
    if (jump) begin
      state_nx = ST_RUN;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_RUN;
        ST_RUN:  if (!space) state_nx = ST_FULL;
        ST_FULL: if (handshake || space) state_nx = ST_RUN;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      fetch_pc   <= '0;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      state      <= state_nx;
      resp_valid <= rom_cs_q && !jump;
      resp_addr  <= rom_addr_q;
      if (jump) begin
        // The redirect request replaces whatever would have been issued this cycle.
        rom_cs_q   <= 1'b1;
        rom_addr_q <= bus.jump_target;
        fetch_pc   <= bus.jump_target + I_ADDR_WIDTH'(1);
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        rom_cs_q <= space;
        if (space) begin
          rom_addr_q <= fetch_pc;
          fetch_pc   <= fetch_pc + I_ADDR_WIDTH'(1);
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        rd_ptr <= rd_ptr + pop_n[PW-1:0];
        count  <= count + CW'(push) - pop_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {resp_addr, bus.rom_data};
  end

  assign bus.rom_addr       = rom_addr_q;
  assign bus.rom_cs         = rom_cs_q;
  assign bus.rom_oe         = rom_cs_q;
  assign bus.instr_valid    = valid;
  assign bus.instr          = valid ? head_word : '0;
  assign bus.instr_ext      = (valid && head_two) ? ext_word : '0;
  assign bus.instr_two_word = valid && head_two;
  assign bus.instr_pc       = valid ? head_addr : '0;
endmodule
